// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: width defaults and state encoding.
package fetch_stage_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives pc to an external combinational memory and
// holds the fetched word in a single IF/ID register with valid/ready handshake.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          PC_W     = PC_W_DEF,
  parameter int unsigned          INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;

  logic accept;
  logic adv;

  assign accept = out_valid_q && out_ready;
  assign adv    = (state_q == RUN) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    // A redirect overrides halt/resume and capture alike, in either state.
    if (branch_taken) begin
      pc_d        = branch_target;
      out_valid_d = 1'b0;
    end else if (state_q == RUN) begin
      if (halt_req) begin
        state_d = HALTED;
        if (accept) begin
          out_valid_d = 1'b0;
        end
      end else if (adv) begin
        out_instr_d = instruction;
        out_pc_d    = pc_q;
        out_valid_d = 1'b1;
        pc_d        = pc_q + PC_W'(1);
      end
    end else begin
      if (accept) begin
        out_valid_d = 1'b0;
      end
      if (resume && !halt_req) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .count (fetch_count)
  );

  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic checked against
// a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [9:0]  pc;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic        halt_req;
  logic        resume;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [1024];
  assign instruction = mem[pc];

  fetch_stage #(
    .PC_W     (10),
    .INSTR_W  (32),
    .RESET_PC (10'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instruction   (instruction),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // reference model state
  int unsigned m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int unsigned m_opc;
  bit          m_halted;
  int unsigned m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_valid = 0; m_instr = '0; m_opc = 0; m_halted = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = m_valid && out_ready;
    if (acc && m_count < 65535) m_count++;
    if (branch_taken) begin
      m_pc = branch_target;
      m_valid = 0;
    end else if (!m_halted) begin
      if (halt_req) begin
        m_halted = 1;
        if (acc) m_valid = 0;
      end else if (!m_valid || out_ready) begin
        m_instr = mem[m_pc];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 1) % 1024;
      end
    end else begin
      if (acc) m_valid = 0;
      if (resume && !halt_req) m_halted = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".instr"}, out_instr, m_instr);
    chk({tag, ".opc"}, 32'(out_pc), 32'(m_opc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    chk({tag, ".count"}, 32'(fetch_count), 32'(m_count));
  endtask

  task automatic step(input string tag, input bit do_chk);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic idle_inputs();
    branch_taken = 0; branch_target = '0; halt_req = 0; resume = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom_range(0, 65535), 6'd0, 10'(i)};
    idle_inputs();
    reset = 1;
    model_reset();
    #2;
    check_all("reset_init");
    @(posedge clk); #1;
    reset = 0;

    // streaming with ready held high
    for (int i = 0; i < 6; i++) begin
      step("stream", 1);
      chk("stream_opc", 32'(out_pc), 32'(i));
      chk("stream_word", out_instr, mem[i]);
    end
    step("stream_last", 1);
    chk("count_six", 32'(fetch_count), 32'd6);

    // stall while out_pc==2
    do_reset();
    step("st0", 1); step("st1", 1); step("st2", 1);
    chk("stall_at2", 32'(out_pc), 32'd2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1);
      chk("stall_opc", 32'(out_pc), 32'd2);
      chk("stall_pc", 32'(pc), 32'd3);
    end
    out_ready = 1;
    step("release", 1);
    chk("release_opc", 32'(out_pc), 32'd3);

    // redirect while holding a valid word
    branch_taken = 1; branch_target = 10'd500;
    step("br", 1);
    chk("br_valid", 32'(out_valid), 32'd0);
    chk("br_pc", 32'(pc), 32'd500);
    idle_inputs();
    step("br_after", 1);
    chk("br_opc", 32'(out_pc), 32'd500);

    // pc wrap
    branch_taken = 1; branch_target = 10'd1022;
    step("wrap_br", 1);
    idle_inputs();
    step("wrap0", 1);
    step("wrap1", 1);
    chk("wrap_1023", 32'(out_pc), 32'd1023);
    step("wrap2", 1);
    chk("wrap_0", 32'(out_pc), 32'd0);

    // halt with a held word
    out_ready = 0; halt_req = 1;
    step("halt", 1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_held", 32'(out_pc), 32'd0);
    halt_req = 0; out_ready = 1;
    step("halt_drain", 1);
    chk("halt_drained", 32'(out_valid), 32'd0);
    step("halt_idle", 1);
    chk("halt_frozen", 32'(pc), 32'd1);
    resume = 1; halt_req = 1;
    step("halt_both", 1);
    chk("halt_wins", 32'(halted), 32'd1);
    halt_req = 0;
    step("resume", 1);
    resume = 0;
    step("resume_fetch", 1);
    chk("resume_opc", 32'(out_pc), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 10'($urandom);
      halt_req      = !branch_taken && ($urandom_range(0, 11) == 0);
      resume        = !branch_taken && ($urandom_range(0, 3) == 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      step("rand", 1);
    end

    // asynchronous reset in the middle of a stall
    idle_inputs();
    step("pre_rst", 1);
    out_ready = 0;
    step("rst_stall", 1);
    #3;
    reset = 1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk); #1;
    reset = 0;
    out_ready = 1;
    step("rst_restart", 1);
    chk("rst_restart_opc", 32'(out_pc), 32'd0);
    chk("rst_restart_word", out_instr, mem[0]);

    // saturation of the accept counter
    for (int i = 0; i < 65600; i++) step("sat", 0);
    check_all("sat");
    chk("sat_ffff", 32'(fetch_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
